// File: rtl/uart_cmd_decoder_if.sv
// Byte stream in from the UART receiver, decoded register write out.
// The decoder is the slave; the byte source / register consumer is the master.
interface uart_cmd_decoder_if;
  logic [7:0]  Rx_Byte;
  logic        Rx_Done;
  logic [7:0]  Cmd;
  logic [7:0]  Reg_Addr;
  logic [15:0] Reg_Data;
  logic        Reg_Wr;
  logic        Chk_Err;
  logic        Tmo_Err;

  modport slave (
    input  Rx_Byte, Rx_Done,
    output Cmd, Reg_Addr, Reg_Data, Reg_Wr, Chk_Err, Tmo_Err
  );

  modport master (
    output Rx_Byte, Rx_Done,
    input  Cmd, Reg_Addr, Reg_Data, Reg_Wr, Chk_Err, Tmo_Err
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes 7-byte frames HDR0 HDR1 CMD ADDR DATA_H DATA_L CHK into a register
// write, with an 8-bit additive checksum and an inter-byte timeout.
//
// state  | meaning
// S_H0   | idle, hunting for HDR0
// S_H1   | HDR0 seen, expecting HDR1
// S_CMD  | expecting command byte
// S_ADDR | expecting address byte
// S_DH   | expecting data high byte
// S_DL   | expecting data low byte
// S_CHK  | expecting checksum byte
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  HDR0        = 8'h55,
  parameter logic [7:0]  HDR1        = 8'hA5
) (
  input logic               Clk,
  input logic               Rst,
  uart_cmd_decoder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_H0, S_H1, S_CMD, S_ADDR, S_DH, S_DL, S_CHK
  } state_t;

  state_t state, nxt_state;

  logic [7:0]       rx_byte;
  logic             rx_done;
  logic [7:0]       acc;
  logic [7:0]       sh_cmd, sh_addr, sh_dh, sh_dl;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       cmd_q, addr_q;
  logic [15:0]      data_q;
  logic             wr_q, chk_err_q, tmo_err_q;

  logic acc_clr, acc_add, wr_set, chk_set, tmo_set;

  assign rx_byte = bus.Rx_Byte;
  assign rx_done = bus.Rx_Done;

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_H0;
    else     state <= nxt_state;
  end

  // A received byte always wins over the timeout in the same cycle.
  always_comb begin
    nxt_state = state;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    wr_set    = 1'b0;
    chk_set   = 1'b0;
    tmo_set   = 1'b0;
    if (rx_done) begin
      case (state)
        S_H0: if (rx_byte == HDR0) nxt_state = S_H1;
        S_H1: begin
          if (rx_byte == HDR1) begin
            nxt_state = S_CMD;
            acc_clr   = 1'b1;
          end else if (rx_byte == HDR0) begin
            nxt_state = S_H1;
          end else begin
            nxt_state = S_H0;
          end
        end
        S_CMD:  begin nxt_state = S_ADDR; acc_add = 1'b1; end
        S_ADDR: begin nxt_state = S_DH;   acc_add = 1'b1; end
        S_DH:   begin nxt_state = S_DL;   acc_add = 1'b1; end
        S_DL:   begin nxt_state = S_CHK;  acc_add = 1'b1; end
        S_CHK: begin
          nxt_state = S_H0;
          if (acc == rx_byte) wr_set  = 1'b1;
          else                chk_set = 1'b1;
        end
        default: nxt_state = S_H0;
      endcase
    end else if (state != S_H0 && tmo_cnt == TMO_LAST) begin
      tmo_set   = 1'b1;
      nxt_state = S_H0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmo_cnt   <= '0;
      acc       <= '0;
      sh_cmd    <= '0;
      sh_addr   <= '0;
      sh_dh     <= '0;
      sh_dl     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      chk_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      if (rx_done || state == S_H0) tmo_cnt <= '0;
      else if (tmo_cnt != '1)       tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (acc_clr || tmo_set) acc <= '0;
      else if (acc_add)       acc <= acc + rx_byte;

      if (tmo_set) begin
        sh_cmd  <= '0;
        sh_addr <= '0;
        sh_dh   <= '0;
        sh_dl   <= '0;
      end else if (acc_add) begin
        case (state)
          S_CMD:   sh_cmd  <= rx_byte;
          S_ADDR:  sh_addr <= rx_byte;
          S_DH:    sh_dh   <= rx_byte;
          S_DL:    sh_dl   <= rx_byte;
          default: ;
        endcase
      end

      if (wr_set) begin
        cmd_q  <= sh_cmd;
        addr_q <= sh_addr;
        data_q <= {sh_dh, sh_dl};
      end

      wr_q      <= wr_set;
      chk_err_q <= chk_set;
      tmo_err_q <= tmo_set;
    end
  end

  assign bus.Cmd      = cmd_q;
  assign bus.Reg_Addr = addr_q;
  assign bus.Reg_Data = data_q;
  assign bus.Reg_Wr   = wr_q;
  assign bus.Chk_Err  = chk_err_q;
  assign bus.Tmo_Err  = tmo_err_q;

endmodule
